// File: rtl/proc_pkg.sv
// Shared types and constants for the single-step processor control path:
// opcodes, FSM state codes, ALU selects and instruction field positions.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  // Codes are exported on the debug display, so they are pinned explicitly.
  typedef enum logic [3:0] {
    ST_INIT   = 4'h0,
    ST_FETCH  = 4'h1,
    ST_DECODE = 4'h2,
    ST_NOOP   = 4'h3,
    ST_LOADA  = 4'h4,
    ST_LOADB  = 4'h5,
    ST_STORE  = 4'h6,
    ST_ADD    = 4'h7,
    ST_SUB    = 4'h8,
    ST_HALT   = 4'h9,
    ST_TRAP   = 4'hA
  } state_e;

  localparam int ALU_PASS = 0;
  localparam int ALU_ADD  = 1;
  localparam int ALU_SUB  = 2;

  localparam int OPC_LSB   = 12;
  localparam int DADDR_LSB = 4;
  localparam int RA_LSB    = 8;
  localparam int RB_LSB    = 4;
  localparam int RD_LSB    = 0;

endpackage

// File: rtl/proc_controller.sv
// Multi-cycle Fetch/Decode/Execute control FSM with Moore outputs decoded
// from State and IR. Define CTRL_TRAP_EN to trap on illegal opcodes.
module proc_controller
  import proc_pkg::*;
#(
  parameter int DADDR_W   = 8,
  parameter int RF_AW     = 4,
  parameter int ALU_SEL_W = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [15:0]          IR,
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic                 IR_ld,
  output logic [DADDR_W-1:0]   D_addr,
  output logic                 D_wr,
  output logic                 RF_s,
  output logic [RF_AW-1:0]     RF_W_addr,
  output logic                 RF_W_en,
  output logic [RF_AW-1:0]     RF_Ra_addr,
  output logic [RF_AW-1:0]     RF_Rb_addr,
  output logic [ALU_SEL_W-1:0] ALU_s0,
  output logic [3:0]           State,
  output logic [3:0]           NextState,
  output logic                 Trap
);

  state_e  state_q, state_d;
  opcode_e opcode;
  logic    trap;

  assign opcode    = opcode_e'(IR[OPC_LSB +: 4]);
  assign State     = state_q;
  assign NextState = state_d;
  assign Trap      = trap;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = ST_NOOP;
          OP_STORE: state_d = ST_STORE;
          OP_LOAD:  state_d = ST_LOADA;
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
`ifdef CTRL_TRAP_EN
          default:  state_d = ST_TRAP;
`else
          default:  state_d = ST_NOOP;
`endif
        endcase
      end
      ST_LOADA:  state_d = ST_LOADB;
      ST_NOOP, ST_LOADB, ST_STORE, ST_ADD, ST_SUB:
                 state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
`ifdef CTRL_TRAP_EN
      ST_TRAP:   state_d = ST_TRAP;
`endif
      // Unused codes (and Trap when disabled) recover through Init.
      default:   state_d = ST_INIT;
    endcase
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    trap       = 1'b0;
    case (state_q)
      ST_INIT:  PC_clr = 1'b1;
      ST_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      ST_LOADA: D_addr = IR[DADDR_LSB +: DADDR_W];
      // Address stays up a second cycle for the synchronous RAM read.
      ST_LOADB: begin
        D_addr    = IR[DADDR_LSB +: DADDR_W];
        RF_s      = 1'b1;
        RF_W_addr = IR[RD_LSB +: RF_AW];
        RF_W_en   = 1'b1;
      end
      ST_STORE: begin
        D_addr     = IR[DADDR_LSB +: DADDR_W];
        RF_Ra_addr = IR[RD_LSB +: RF_AW];
        D_wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        RF_Ra_addr = IR[RA_LSB +: RF_AW];
        RF_Rb_addr = IR[RB_LSB +: RF_AW];
        ALU_s0     = (state_q == ST_ADD) ? ALU_SEL_W'(ALU_ADD) : ALU_SEL_W'(ALU_SUB);
        RF_W_addr  = IR[RD_LSB +: RF_AW];
        RF_W_en    = 1'b1;
      end
`ifdef CTRL_TRAP_EN
      ST_TRAP:  trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_controller.sv
// Randomized self-checking bench for proc_controller; expected state traces
// come from per-opcode latency lists and outputs from a per-state table.
module tb_proc_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Trap;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State, NextState;
  logic [2:0]  ALU_s0;

  int testsRun    = 0;
  int testsFailed = 0;

  proc_controller #(.DADDR_W(8), .RF_AW(4), .ALU_SEL_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR),
    .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .ALU_s0(ALU_s0), .State(State), .NextState(NextState), .Trap(Trap)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Output table: what each state should drive, straight from the state list.
  function automatic logic [29:0] expOut(input int st, input logic [15:0] ir);
    logic pcClr = 0, pcUp = 0, irLd = 0, dWr = 0, rfS = 0, wEn = 0, trp = 0;
    logic [7:0] dA = 0;
    logic [3:0] wA = 0, rA = 0, rB = 0;
    logic [2:0] alu = 0;
    case (st)
      0:  pcClr = 1;
      1:  begin irLd = 1; pcUp = 1; end
      4:  dA = ir[11:4];
      5:  begin dA = ir[11:4]; rfS = 1; wA = ir[3:0]; wEn = 1; end
      6:  begin dA = ir[11:4]; rA = ir[3:0]; dWr = 1; end
      7:  begin rA = ir[11:8]; rB = ir[7:4]; alu = 1; wA = ir[3:0]; wEn = 1; end
      8:  begin rA = ir[11:8]; rB = ir[7:4]; alu = 2; wA = ir[3:0]; wEn = 1; end
      10: trp = 1;
      default: ;
    endcase
    return {pcClr, pcUp, irLd, dA, dWr, rfS, wA, wEn, rA, rB, alu, trp};
  endfunction

  function automatic logic [29:0] obsOut();
    return {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
            RF_Ra_addr, RF_Rb_addr, ALU_s0, Trap};
  endfunction

  task automatic checkCycle(input string tag, input int expState, input int expNext,
                            input logic [15:0] ir);
    checkOutput({tag, ".State"}, 32'(State), 32'(expState));
    checkOutput({tag, ".Next"}, 32'(NextState), 32'(expNext));
    checkOutput({tag, ".Outs"}, 32'(obsOut()), 32'(expOut(expState, ir)));
  endtask

  task automatic applyStimulus(input logic [15:0] ir);
    IR = ir;
  endtask

  // Called just after a negedge with the DUT in Fetch. Returns 1 if the
  // instruction ends in a terminal state (Halt or Trap).
  task automatic runInstr(input logic [15:0] ir, output bit terminal);
    int seq[$];
    int holdState;
    string tag;
    int op = int'(ir[15:12]);
    $sformat(tag, "ir%04h", ir);
    applyStimulus(ir);
    seq = '{1, 2};
    holdState = -1;
    case (op)
      0: seq.push_back(3);
      1: seq.push_back(6);
      2: begin seq.push_back(4); seq.push_back(5); end
      3: seq.push_back(7);
      4: seq.push_back(8);
      5: holdState = 9;
      default: begin
`ifdef CTRL_TRAP_EN
        holdState = 10;
`else
        seq.push_back(3);
`endif
      end
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      checkCycle(tag, seq[i], (i + 1 < seq.size()) ? seq[i+1]
                              : ((holdState >= 0) ? holdState : 1), ir);
      @(negedge Clk);
    end
    terminal = (holdState >= 0);
    if (terminal) begin
      for (int k = 0; k < 20; k++) begin
        checkCycle({tag, ".hold"}, holdState, holdState, ir);
        @(negedge Clk);
      end
    end
  endtask

  task automatic resetAndStart();
    Reset = 1'b0;
    IR = 16'(IR ^ 16'h5A5A);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checkCycle("reset", 0, 1, IR);
    end
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  function automatic logic [15:0] randIr(input bit allowIllegal);
    logic [11:0] lo = 12'($urandom());
    logic [3:0]  op = 4'($urandom_range(0, 4));
    if (allowIllegal && $urandom_range(0, 5) == 0) op = 4'($urandom_range(6, 15));
    return {op, lo};
  endfunction

  initial begin
    bit term;
    bit illegalIsNoop;
`ifdef CTRL_TRAP_EN
    illegalIsNoop = 1'b0;
`else
    illegalIsNoop = 1'b1;
`endif
    IR = 16'h0000;

    resetAndStart();
    runInstr(16'h3125, term);
    runInstr(16'h21B3, term);
    runInstr(16'h1407, term);
    runInstr(16'h4A5C, term);
    runInstr(16'h0FFF, term);
    for (int i = 0; i < 40; i++) runInstr(randIr(illegalIsNoop), term);
    runInstr(16'h5000, term);
    checkOutput("haltTerminal", 32'(term), 32'd1);

    // Asynchronous reset asserted in the middle of LoadA.
    resetAndStart();
    applyStimulus(16'h21B3);
    checkCycle("midA", 1, 2, IR);
    @(negedge Clk);
    checkCycle("midA", 2, 4, IR);
    @(negedge Clk);
    checkCycle("midA", 4, 5, IR);
    #2 Reset = 1'b0;
    #1 checkCycle("midA.async", 0, 1, IR);
    for (int k = 0; k < 2; k++) begin
      @(posedge Clk);
      #1 checkOutput("midA.noPulse", 32'({RF_W_en, D_wr}), 32'd0);
      @(negedge Clk);
      checkCycle("midA.held", 0, 1, IR);
    end
    Reset = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 30; i++) runInstr(randIr(illegalIsNoop), term);
    runInstr(16'hF000, term);
`ifdef CTRL_TRAP_EN
    checkOutput("trapTerminal", 32'(term), 32'd1);
`else
    checkOutput("illegalNoTrap", 32'(term), 32'd0);
    checkCycle("afterIllegal", 1, 2, IR);
`endif

    resetAndStart();
    for (int i = 0; i < 20; i++) runInstr(randIr(1'b0), term);
    runInstr({4'h5, 12'($urandom())}, term);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
